irq_timer: RTL and testbench

IRQ_TIMER -- requirements
Module: irq_timer

---
 rtl/irq_timer.sv | 138 +++++++++++++
 tb/tb_irq_timer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_timer.sv
// irq_timer: periodic tick generator that raises a level interrupt and
// tracks ticks that are lost while that interrupt is still pending.
//
// Optional feature macro: IRQ_TIMER_OVERRUN_EN
//   defined   -> overrun counter built (saturating, clearable by clr_ovr)
//   undefined -> overrun_cnt tied to 0, clr_ovr ignored
//
// Ports
//   clk          rising-edge clock
//   srst         synchronous active-high reset
//   enable       1 = run, 0 = return to idle
//   period       terminal count P; one tick every P+1 cycles
//   ack          interrupt acknowledge level (rising edge acknowledges)
//   clr_ovr      one-cycle pulse clearing overrun_cnt
//   irq          level interrupt, registered
//   count        current counter value, registered
//   overrun_cnt  ticks lost while irq was pending
module irq_timer #(
    parameter int unsigned WIDTH     = 27,
    parameter int unsigned OVR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     period,
    input  logic                 ack,
    input  logic                 clr_ovr,
    output logic                 irq,
    output logic [WIDTH-1:0]     count,
    output logic [OVR_WIDTH-1:0] overrun_cnt
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StArmed   = 2'd1;
    localparam logic [1:0] StPending = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             irq_q, irq_d;
    logic             ack_q;
    logic             ack_rise;
    logic             tick;

    assign ack_rise = ack & ~ack_q;
    // count sits at 0 in idle, so the state guard keeps P=0 from ticking there
    assign tick     = (state_q != StIdle) && (count_q == period_q);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        if (!enable) begin
            state_d = StIdle;
            count_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d  = StArmed;
                    count_d  = '0;
                    period_d = period;
                end
                StArmed, StPending: begin
                    if (tick) begin
                        count_d  = '0;
                        period_d = period;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (state_q == StArmed) begin
                        if (tick) begin
                            state_d = StPending;
                        end
                    end else if (ack_rise && !tick) begin
                        // a tick coinciding with the ack re-arms the interrupt at once
                        state_d = StArmed;
                    end
                end
                default: begin
                    state_d = StIdle;
                    count_d = '0;
                end
            endcase
        end
        irq_d = (state_d == StPending);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            period_q <= '0;
            irq_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            irq_q    <= irq_d;
            ack_q    <= ack;
        end
    end

    assign irq   = irq_q;
    assign count = count_q;

`ifdef IRQ_TIMER_OVERRUN_EN
    logic [OVR_WIDTH-1:0] ovr_q, ovr_d;
    logic                 ovr_inc;

    // disable wins over a coincident lost tick
    assign ovr_inc = enable && (state_q == StPending) && tick && !ack_rise;

    always_comb begin
        ovr_d = ovr_q;
        if (clr_ovr) begin
            ovr_d = '0;
        end else if (ovr_inc && (ovr_q != '1)) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_cnt = ovr_q;
`else
    logic unused_clr_ovr;
    assign unused_clr_ovr = clr_ovr;
    assign overrun_cnt    = '0;
`endif

endmodule

// File: tb/tb_irq_timer.sv
module tb_irq_timer;

    localparam int unsigned W       = 27;
    localparam int unsigned OVW     = 2;
    localparam int unsigned OVR_MAX = (1 << OVW) - 1;
`ifdef IRQ_TIMER_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           srst = 1'b1;
    logic           enable = 1'b0;
    logic [W-1:0]   period = '0;
    logic           ack = 1'b0;
    logic           clr_ovr = 1'b0;
    logic           irq;
    logic [W-1:0]   count;
    logic [OVW-1:0] overrun_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model: running/pending flags and integer counters
    bit          m_run, m_pend, m_ack_prev;
    int unsigned m_cnt, m_p, m_ovr;

    irq_timer #(
        .WIDTH    (W),
        .OVR_WIDTH(OVW)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .enable     (enable),
        .period     (period),
        .ack        (ack),
        .clr_ovr    (clr_ovr),
        .irq        (irq),
        .count      (count),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // advance the model by one clock edge using the inputs currently applied
    task automatic model_step();
        bit ack_edge;
        bit tick;
        ack_edge = ack && !m_ack_prev;
        if (srst) begin
            m_run = 0; m_pend = 0; m_ack_prev = 0;
            m_cnt = 0; m_p = 0; m_ovr = 0;
        end else begin
            m_ack_prev = ack;
            if (!enable) begin
                m_run = 0; m_pend = 0; m_cnt = 0;
            end else if (!m_run) begin
                m_run = 1; m_cnt = 0; m_p = period;
            end else begin
                tick = (m_cnt == m_p);
                if (tick) begin
                    m_cnt = 0;
                    m_p   = period;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                if (!m_pend) begin
                    if (tick) m_pend = 1;
                end else if (tick && !ack_edge) begin
                    if (OVR_EN && m_ovr < OVR_MAX) m_ovr = m_ovr + 1;
                end else if (ack_edge && !tick) begin
                    m_pend = 0;
                end
            end
            if (OVR_EN && clr_ovr) m_ovr = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("count", 32'(count), m_cnt);
        check("irq", 32'(irq), 32'(m_pend));
        check("overrun_cnt", 32'(overrun_cnt), m_ovr);
    endtask

    task automatic do_reset(input int unsigned p);
        srst = 1; enable = 1; ack = 0; clr_ovr = 0; period = W'(p);
        repeat (2) cycle();
        srst = 0;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (n < 300 && irq !== 1'b1) begin
            cycle();
            n++;
        end
        if (irq !== 1'b1) check("irq_timeout", 32'(irq), 1);
    endtask

    task automatic wait_count(input int unsigned v);
        int n;
        n = 0;
        while (n < 300 && count !== W'(v)) begin
            cycle();
            n++;
        end
        if (count !== W'(v)) check("count_timeout", 32'(count), v);
    endtask

    initial begin
        int n;
        int unsigned saved;

        // long reset, P=9, ack tied low
        srst = 1; enable = 1; period = 9; ack = 0; clr_ovr = 0;
        repeat (16) cycle();
        check("reset_count", 32'(count), 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_ovr", 32'(overrun_cnt), 0);
        srst = 0;
        wait_irq(n);
        check("irq_rise_latency", n, 11);
        repeat (30) cycle();
        check("ovr_after_30", 32'(overrun_cnt), OVR_EN ? 32'd3 : 32'd0);
        check("irq_held", 32'(irq), 1);

        // acknowledge held for 3 cycles counts once
        do_reset(4);
        wait_irq(n);
        repeat (2) cycle();
        ack = 1;
        cycle();
        check("irq_fall_on_ack", 32'(irq), 0);
        repeat (2) cycle();
        ack = 0;
        wait_irq(n);
        check("rerise_on_tick", 32'(count), 0);
        check("ovr_single_ack", 32'(overrun_cnt), 0);

        // ack edge on the tick cycle while pending
        do_reset(4);
        wait_irq(n);
        wait_count(4);
        ack = 1;
        cycle();
        check("irq_tick_ack", 32'(irq), 1);
        check("ovr_tick_ack", 32'(overrun_cnt), 0);
        ack = 0;
        cycle();

        // saturation with P=0, then clear
        do_reset(0);
        repeat (10) cycle();
        check("ovr_saturate", 32'(overrun_cnt), OVR_EN ? 32'd3 : 32'd0);
        clr_ovr = 1;
        cycle();
        clr_ovr = 0;
        check("ovr_clear", 32'(overrun_cnt), 0);

        // period change mid-count applies from the next period
        do_reset(100);
        wait_count(50);
        period = 3;
        wait_count(100);
        cycle();
        check("old_period_wrap", 32'(count), 0);
        repeat (3) cycle();
        check("new_period_cnt3", 32'(count), 3);
        cycle();
        check("new_period_wrap", 32'(count), 0);

        // disable while pending, then reset mid-count
        do_reset(2);
        repeat (15) cycle();
        check("pending_before_dis", 32'(irq), 1);
        saved = m_ovr;
        enable = 0;
        cycle();
        check("dis_irq", 32'(irq), 0);
        check("dis_count", 32'(count), 0);
        check("dis_ovr_kept", 32'(overrun_cnt), saved);
        check("dis_ovr_value", 32'(overrun_cnt), OVR_EN ? 32'd3 : 32'd0);
        enable = 1;
        repeat (5) cycle();
        srst = 1;
        cycle();
        check("srst_irq", 32'(irq), 0);
        check("srst_count", 32'(count), 0);
        check("srst_ovr", 32'(overrun_cnt), 0);
        srst = 0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            srst    = ($urandom_range(0, 199) == 0);
            enable  = ($urandom_range(0, 39) != 0);
            clr_ovr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) ack = ~ack;
            if ($urandom_range(0, 7) == 0) period = W'($urandom_range(0, 6));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
